// File: rtl/nested_loop_counter.sv
// NUM_LOOPS-deep nested loop counter with programmable per-level trip counts.
// Level 0 is innermost; carries ripple outward; optional auto-restart.
`timescale 1ns/1ps
module nested_loop_counter #(
    parameter int NUM_LOOPS = 4,
    parameter int OUTW      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      incr,
    input  logic                      cont,
    input  logic [NUM_LOOPS*OUTW-1:0] bounds,
    output logic [NUM_LOOPS*OUTW-1:0] count,
    output logic [NUM_LOOPS-1:0]      wrap,
    output logic                      last,
    output logic                      busy,
    output logic                      done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [OUTW-1:0] ONE = OUTW'(1);

    logic [1:0]                state_q, state_d;
    logic [NUM_LOOPS*OUTW-1:0] bounds_q, bounds_d;
    logic [NUM_LOOPS*OUTW-1:0] count_q, count_d;
    logic                      cont_q, cont_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [NUM_LOOPS-1:0] at_max;
    logic [NUM_LOOPS:0]   carry;
    logic                 accept;
    logic [OUTW-1:0]      lvl_bound;
    logic [OUTW-1:0]      lvl_max;

    // A latched bound of zero behaves as one: the level sits at maximum forever.
    always_comb begin
        lvl_bound = '0;
        lvl_max   = '0;
        at_max    = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            lvl_bound = bounds_q[i*OUTW +: OUTW];
            lvl_max   = (lvl_bound == '0) ? '0 : lvl_bound - ONE;
            at_max[i] = (count_q[i*OUTW +: OUTW] == lvl_max);
        end
    end

    assign accept = (state_q == S_RUN) & incr & ~clr & ~reset;

    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            carry[i+1] = carry[i] & at_max[i];
        end
    end

    always_comb begin
        wrap = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            wrap[i] = accept & carry[i] & at_max[i];
        end
    end

    assign last = (state_q == S_RUN) & (&at_max);

    always_comb begin
        state_d  = state_q;
        bounds_d = bounds_q;
        cont_d   = cont_q;
        count_d  = count_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        bounds_d = bounds;
                        cont_d   = cont;
                        count_d  = '0;
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        for (int i = 0; i < NUM_LOOPS; i++) begin
                            if (carry[i]) begin
                                count_d[i*OUTW +: OUTW] = at_max[i] ? '0
                                    : count_q[i*OUTW +: OUTW] + ONE;
                            end
                        end
                        // Terminal step: every level rolls over together.
                        if (&at_max) begin
                            done_d = 1'b1;
                            if (!cont_q) begin
                                state_d = S_DONE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            bounds_q <= '0;
            cont_q   <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bounds_q <= bounds_d;
            cont_q   <= cont_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_nested_loop_counter.sv
// Bench for nested_loop_counter: driver pushes expected per-cycle outputs from a
// linear-index reference model; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_nested_loop_counter;

    localparam int NL = 4;
    localparam int W  = 16;
    localparam int EW = NL*W + NL + 3;

    logic              clk = 1'b0;
    logic              reset, clr, start, incr, cont;
    logic [NL*W-1:0]   bounds;
    logic [NL*W-1:0]   count;
    logic [NL-1:0]     wrap;
    logic              last, busy, done;

    nested_loop_counter #(.NUM_LOOPS(NL), .OUTW(W)) dut (
        .clk(clk), .reset(reset), .clr(clr), .start(start), .incr(incr),
        .cont(cont), .bounds(bounds), .count(count), .wrap(wrap),
        .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: position in the pass as a single linear index.
    int              m_state;   // 0 idle, 1 run, 2 done
    longint unsigned m_idx;
    longint unsigned m_eb[NL];
    bit              m_done, m_cont;

    function automatic longint unsigned prod_below(input int n);
        longint unsigned p = 1;
        for (int l = 0; l < n; l++) p = p * m_eb[l];
        return p;
    endfunction

    function automatic logic [NL*W-1:0] pk(input int b3, input int b2, input int b1, input int b0);
        return {W'(b3), W'(b2), W'(b1), W'(b0)};
    endfunction

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_done = 0; m_cont = 0;
        for (int l = 0; l < NL; l++) m_eb[l] = 1;
    endtask

    task automatic drive(input bit r, input bit c, input bit s, input bit i,
                         input bit co, input logic [NL*W-1:0] b);
        logic [NL*W-1:0] ec;
        logic [NL-1:0]   ew;
        longint unsigned total, cnt;
        bit run, acc, el;
        @(posedge clk); #1;
        reset = r; clr = c; start = s; incr = i; cont = co; bounds = b;
        total = prod_below(NL);
        run   = (m_state == 1);
        acc   = run && i && !r && !c;
        for (int l = 0; l < NL; l++) begin
            cnt = (m_idx / prod_below(l)) % m_eb[l];
            ec[l*W +: W] = W'(cnt);
            ew[l] = acc && (((m_idx + 1) % prod_below(l+1)) == 0);
        end
        el = run && (m_idx == total - 1);
        exp_q.push_back({ec, run, m_done, ew, el});
        if (r) model_reset();
        else if (c) begin
            m_state = 0; m_idx = 0; m_done = 0;
        end else begin
            case (m_state)
                0: begin
                    m_done = 0;
                    if (s) begin
                        for (int l = 0; l < NL; l++)
                            m_eb[l] = (b[l*W +: W] == 0) ? 1 : longint'(b[l*W +: W]);
                        m_cont = co; m_idx = 0; m_state = 1;
                    end
                end
                1: begin
                    m_done = 0;
                    if (i) begin
                        if (m_idx == total - 1) begin
                            m_idx = 0; m_done = 1;
                            if (!m_cont) m_state = 2;
                        end else m_idx = m_idx + 1;
                    end
                end
                default: begin
                    m_done = 0; m_state = 0;
                end
            endcase
        end
    endtask

    task automatic step(input bit s, input bit i, input bit co, input logic [NL*W-1:0] b);
        drive(1'b0, 1'b0, s, i, co, b);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count", count, e[EW-1 -: NL*W]);
            check("busy", 64'(busy), 64'(e[NL+2]));
            check("done", 64'(done), 64'(e[NL+1]));
            check("wrap", 64'(wrap), 64'(e[NL:1]));
            check("last", 64'(last), 64'(e[0]));
        end
    end

    initial begin
        logic [NL*W-1:0] b;
        int k;
        reset = 1'b1; clr = 1'b0; start = 1'b0; incr = 1'b0; cont = 1'b0; bounds = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Basic single pass, 2x3 inner nest.
        b = pk(1, 1, 2, 3);
        step(1, 0, 0, b);
        repeat (8) step(0, 1, 0, b);
        repeat (2) step(0, 0, 0, b);

        // Continuous mode, two passes, then clear.
        step(1, 0, 1, b);
        repeat (12) step(0, 1, 1, b);
        drive(0, 1, 0, 0, 0, b);

        // Gapped increments on a 4-step inner loop.
        b = pk(1, 1, 1, 4);
        step(1, 0, 0, b);
        for (int j = 0; j < 20; j++) step(0, (j % 3) == 0, 0, b);

        // Zero bounds behave as one.
        b = pk(0, 0, 0, 5);
        step(1, 0, 0, b);
        repeat (7) step(0, 1, 0, b);

        // Clear mid-run, ignored incr, fresh run.
        b = pk(1, 1, 2, 3);
        step(1, 0, 0, b);
        repeat (2) step(0, 1, 0, b);
        drive(0, 1, 0, 1, 0, b);
        step(0, 1, 0, b);
        step(1, 0, 0, b);
        repeat (3) step(0, 1, 0, b);
        drive(0, 1, 0, 0, 0, b);

        // start during RUN with different bounds is ignored.
        step(1, 0, 0, pk(1, 1, 2, 3));
        step(0, 1, 0, b);
        step(1, 1, 0, pk(1, 1, 3, 5));
        repeat (6) step(0, 1, 0, pk(2, 2, 3, 5));

        // clr+start together stays idle; incr in idle ignored.
        drive(0, 1, 1, 0, 0, b);
        repeat (2) step(0, 1, 0, b);

        // start+incr in IDLE: incr dropped.
        step(1, 1, 0, b);
        repeat (7) step(0, 1, 0, b);

        // Reset while in DONE.
        b = pk(1, 1, 1, 2);
        step(1, 0, 0, b);
        repeat (2) step(0, 1, 0, b);
        drive(1, 0, 0, 0, 0, b);
        repeat (2) step(0, 0, 0, b);

        // Full-width bound on level 0: single carry into level 1.
        b = pk(1, 1, 3, 16'hFFFF);
        step(1, 0, 0, b);
        repeat (65536) step(0, 1, 0, b);
        drive(0, 1, 0, 0, 0, b);

        // Randomised traffic, bounds input changing every cycle.
        for (int j = 0; j < 1500; j++) begin
            b = {W'($urandom_range(3, 0)), W'($urandom_range(3, 0)),
                 W'($urandom_range(3, 0)), W'($urandom_range(3, 0))};
            drive($urandom_range(99, 0) < 1, $urandom_range(99, 0) < 2,
                  $urandom_range(99, 0) < 10, $urandom_range(99, 0) < 70,
                  1'($urandom_range(1, 0)), b);
        end
        repeat (2) step(0, 0, 0, b);

        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nested_loop_counter.md
Name: nested_loop_counter

Overview:
- Parametrised successor to the team's single-level clear/increment counter.
- Provides NUM_LOOPS nested counters with runtime-programmable bounds, carry propagation between levels, per-level wrap flags, a last-iteration flag, a completion pulse and an optional continuous (auto-restart) mode.
- Sits in the convolution controller and generates the row, column and kernel-index sequences that drive address generation and MAC sequencing.

Parameters:
- NUM_LOOPS, 4, number of nested levels; level 0 is innermost; legal range 1..8.
- OUTW, 16, width of each level's count and bound.

Ports:
- clk  input  1  clock.
- reset  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous clear; returns block to IDLE; highest priority after reset.
- start  input  1  latch bounds and mode, begin a run; honoured only in IDLE.
- incr  input  1  advance the loop nest by one step; honoured only in RUN.
- cont  input  1  mode, sampled with start; 1 = continuous, 0 = single pass.
- bounds  input  NUM_LOOPS*OUTW  trip count per level; level i in bits [i*OUTW +: OUTW].
- count  output  NUM_LOOPS*OUTW  current index per level, same packing as bounds; registered.
- wrap  output  NUM_LOOPS  combinational; wrap[i] = accepted incr this cycle causes level i to roll over.
- last  output  1  combinational; RUN and every level at its maximum (bound-1).
- busy  output  1  registered; high in RUN.
- done  output  1  registered; one-cycle pulse after the terminal step.

Behaviour:
- Reset: state IDLE; count all zero; busy=0; done=0; latched bounds zero; latched cont=0. Reset mid-run aborts with no done pulse.
- Priority each cycle: reset > clr > start/incr. clr has the same effect as reset on state, count, busy and done, including in RUN; no done pulse.
- States are IDLE, RUN and DONE.
  - IDLE: start=1 latches bounds and cont, count set to 0, next state RUN, busy=1 from the next cycle. incr is ignored in IDLE.
  - RUN: start is ignored; bounds are not re-sampled. Any change on the bounds input mid-run has no effect.
  - RUN with incr=1:
    - Level 0 increments.
    - Level i increments only if levels 0..i-1 are all at their maximum.
    - A level at its maximum that receives a carry rolls over to 0.
  - Terminal step (incr=1 while last=1): all levels roll to 0 and wrap is all ones.
    - cont=0: next state DONE.
    - cont=1: stay in RUN, busy stays 1.
    - In both modes done=1 the following cycle.
  - DONE: lasts one cycle (done=1, busy=0), then returns to IDLE. start in DONE is ignored.
- Bound rule: a latched bound of 0 is treated as 1, so that level is permanently at maximum and its count stays 0. Maximum for level i = max(bound_i,1) − 1.
- Total steps per pass = product of effective bounds. Internal arithmetic is per-level OUTW-bit; no cross-level arithmetic widening.
- wrap[i] is asserted only when incr is accepted (RUN). It is 0 in IDLE/DONE and when incr=0.
- last is combinational from registered count and latched bounds. It is high in RUN while the nest sits on its final index, regardless of incr.
- Latency: count reflects an accepted incr on the next clock edge. done rises on the clock edge after the terminal step.
- Simultaneous start+incr in IDLE: start taken, incr dropped; the first incr is honoured on the cycle after entering RUN.
- Simultaneous clr+start: clr wins; block stays in IDLE.

Test Plan:
- Reset, then bounds={L3=1,L2=1,L1=2,L0=3}, cont=0, start, then incr every cycle:
  - count sequence (L1,L0) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
  - wrap[0] high on steps 3 and 6; wrap[1] high on step 6.
  - last high at (1,2).
  - done pulses once on the cycle after step 6; busy low from then on; state returns to IDLE.
- Same bounds with cont=1, 12 incrs: done pulses after step 6 and after step 12; busy stays 1 throughout; count is (0,0) after each pass.
- Gapped incr (1,0,0,1,…) with L0=4: count advances only on incr cycles; wrap stays 0 on idle cycles.
- Zero-bound case, bounds={0,0,0,5}: exactly 5 steps to done; levels 1-3 read 0 throughout; last high at L0=4.
- clr asserted mid-run at count L0=2: next cycle count=0, busy=0, done=0. A following incr has no effect; a following start begins a fresh run.
- Corner cases:
  - start during RUN with different bounds: ignored, original bounds still used.
  - clr+start in the same cycle: block stays in IDLE.
  - reset during DONE: done deasserted the next cycle.
  - OUTW=16 bound 16'hFFFF on L0: rollover from 16'hFFFE to 0 with no overflow into L1 beyond a single carry.
